dnn_param_loader: RTL and testbench
===================================

// Module: dnn_param_loader
// PURPOSE
//  Upstream feeder of the 4-4-2 DNN datapath: accepts a 5-bit signed serial word stream (valid/ready),
//  assembles inputs x0..x3 and weights w04..w37, w48..w79 into shadow registers, then commits them
//  atomically to parallel outputs and pulses in_ready for one cycle. Holds the committed weights stable
//  for HOLD_CYC cycles after the pulse, so layer-2 weights stay valid until the pipeline consumes them.
// PARAMETERS
//  DW       5  word width (signed two's complement)
//  N_IN     4  inputs / layer-1 rows
//  N_HID    4  hidden neurons
//  N_OUT    2  outputs
//  HOLD_CYC 2  cycles after the in_ready pulse during which outputs must not change
// PORTS
//  clk            in   1        single clock, all logic posedge
//  rst_n          in   1        synchronous reset, active-low
//  s_valid        in   1        stream word valid
//  s_ready        out  1        loader can accept word
//  s_data         in   DW       stream word
//  s_wload        in   1        sampled on first word of frame: 1 = full frame (28 words), 0 = x-only (4 words)
//  s_last         in   1        marks final word of frame
//  x_flat         out  N_IN*DW  x_flat[DW*k +: DW] = xk
//  w1_flat        out  80       w1_flat[DW*(4i+j) +: DW] = w{i}{j+4}
//  w2_flat        out  40       w2_flat[DW*(2i+j) +: DW] = w{i+4}{j+8}
//  in_ready       out  1        one-cycle pulse: outputs hold a new complete frame
//  weights_valid  out  1        at least one full frame committed since reset
//  frame_err      out  1        one-cycle pulse: framing error, frame discarded
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all outputs 0, s_ready 0 in the reset cycle, then 1.
//    Counter, shadow, pending flag and hold counter cleared. Reset mid-frame discards the partial frame.
//  - Transfer: a word is accepted when s_valid && s_ready at posedge.
//  - Word order, full frame: x0..x3, w04,w05,w06,w07,w14..w17,w24..w27,w34..w37, w48,w49,w58,w59,w68,w69,w78,w79.
//  - Word order, x-only frame: x0..x3. Its weight outputs keep the last committed values.
//  - Word counter 0..27 (5 bits). Mode is latched on word 0 and ignored on later words.
//  - s_last must be 1 on exactly the final word (idx 27 full / idx 3 x-only):
//    - s_last early or missing on final word -> frame_err pulse the next cycle.
//      The counter returns to 0, the shadow is not committed, and a missing s_last is not resynchronised.
//    - An x-only frame completing while weights_valid=0 -> frame_err, discarded.
//  - States:
//    - LOAD: accepting words.
//    - PEND: complete frame in shadow, waiting for commit; s_ready=0.
//  - Commit condition: (PEND or final word accepted this edge) && hold_cnt==0.
//    - At that edge, outputs <= shadow (x only for x-only frames) and in_ready <= 1 for one cycle.
//    - hold_cnt <= HOLD_CYC; weights_valid <= 1 if full frame; state returns to LOAD.
//  - Latency: final word accepted at edge E, no hold pending -> outputs and in_ready valid in cycle after E.
//    Back-to-back x-only frames give at most one in_ready every HOLD_CYC+1 cycles.
//  - hold_cnt decrements each cycle while nonzero. Loading the next frame into the shadow proceeds during hold.
//    Shadow writes never touch the outputs.
//  - Simultaneous events:
//    - Final word accepted while hold_cnt!=0 -> enter PEND, commit on the first edge with hold_cnt==0.
//    - frame_err and in_ready never pulse in the same cycle.
//  - Arithmetic: none. Values pass bit-exact, no sign conversion.
// STRUCTURE
//  - dnn_pkg: DW, N_IN, N_HID, N_OUT, FRAME_FULL=28, FRAME_X=4, state enum {LOAD, PEND}, word-index constants.
//  - Single module; no sub-module needed (counter + shadow + hold timer fit in ~200 lines).
// TESTING
//  1. Reset, then full frame words 1..28 (w79=-4, s_last on 28)
//     -> in_ready pulse 1 cycle after last accept; x_flat[4:0]=1, w2_flat[39:35]=-4; weights_valid=1.
//  2. Full frame, then x-only frame {-16,15,0,-1} with s_valid held high
//     -> second in_ready no earlier than 3 cycles after the first; w1_flat/w2_flat unchanged; x3=-1.
//  3. x-only frame directly after reset -> frame_err pulse, no in_ready, outputs stay 0.
//  4. Full frame with s_last on word 20 -> frame_err the next cycle, outputs unchanged;
//     the following correct frame commits normally.
//  5. rst_n=0 at word 15 of a frame, then a fresh full frame -> only the fresh values appear;
//     a single in_ready pulse.
//  6. s_valid toggled randomly, 50% -> committed values match a reference model; s_ready=0 only in PEND.

Source files
------------

// File: rtl/dnn_param_loader_pkg.sv
// Shared sizes, frame layout and FSM state type for the 4-4-2 DNN parameter loader.
package dnn_param_loader_pkg;

  localparam int unsigned DW         = 5;
  localparam int unsigned N_IN       = 4;
  localparam int unsigned N_HID      = 4;
  localparam int unsigned N_OUT      = 2;
  localparam int unsigned HOLD_CYC   = 2;

  localparam int unsigned FRAME_FULL = N_IN + N_IN * N_HID + N_HID * N_OUT;  // 28
  localparam int unsigned FRAME_X    = N_IN;                                 // 4
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned HOLD_W     = $clog2(HOLD_CYC + 1);

  localparam int unsigned X_W        = N_IN * DW;
  localparam int unsigned W1_W       = N_IN * N_HID * DW;
  localparam int unsigned W2_W       = N_HID * N_OUT * DW;
  localparam int unsigned SHD_W      = FRAME_FULL * DW;

  // Word-index boundaries inside a frame; the shadow is laid out in arrival order.
  localparam int unsigned IDX_W1     = N_IN;
  localparam int unsigned IDX_W2     = N_IN + N_IN * N_HID;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] last_idx(input logic full);
    return full ? CNT_W'(FRAME_FULL - 1) : CNT_W'(FRAME_X - 1);
  endfunction

endpackage

// File: rtl/dnn_param_loader.sv
// Serial-to-parallel loader: assembles a frame in a shadow, then commits it atomically
// to the parallel outputs, spacing commits by a hold window so consumers see stable weights.
module dnn_param_loader
  import dnn_param_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_wload,
  input  logic              s_last,
  output logic [X_W-1:0]    x_flat,
  output logic [W1_W-1:0]   w1_flat,
  output logic [W2_W-1:0]   w2_flat,
  output logic              in_ready,
  output logic              weights_valid,
  output logic              frame_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                full_q, full_d;
  logic [SHD_W-1:0]    shd_q, shd_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                ready_q, ready_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [W1_W-1:0]     w1_q, w1_d;
  logic [W2_W-1:0]     w2_q, w2_d;
  logic                in_ready_q, in_ready_d;
  logic                wv_q, wv_d;
  logic                err_q, err_d;

  logic                accept_c;
  logic                cur_full_c;
  logic                final_c;
  logic                commit_c;

  // Mode is taken live from s_wload on word 0 and from the latched flag afterwards.
  assign accept_c   = s_valid & ready_q;
  assign cur_full_c = (cnt_q == '0) ? s_wload : full_q;
  assign final_c    = (cnt_q == last_idx(cur_full_c));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shd_d      = shd_q;
    hold_d     = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    x_d        = x_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    in_ready_d = 1'b0;
    wv_d       = wv_q;
    err_d      = 1'b0;
    commit_c   = 1'b0;

    if (accept_c) begin
      if (cnt_q < CNT_W'(FRAME_FULL)) begin
        shd_d[DW*int'(cnt_q) +: DW] = s_data;
      end
      full_d = cur_full_c;
      if (s_last != final_c) begin
        // Early or missing s_last: drop the frame and restart counting from the next word.
        err_d = 1'b1;
        cnt_d = '0;
      end else if (final_c) begin
        cnt_d = '0;
        if (!cur_full_c && !wv_q) begin
          err_d = 1'b1;
        end else if (hold_q == '0) begin
          commit_c = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (state_q == ST_PEND && hold_q == '0) begin
      commit_c = 1'b1;
    end

    if (commit_c) begin
      x_d        = shd_d[X_W-1:0];
      if (full_d) begin
        w1_d = shd_d[DW*IDX_W1 +: W1_W];
        w2_d = shd_d[DW*IDX_W2 +: W2_W];
        wv_d = 1'b1;
      end
      in_ready_d = 1'b1;
      hold_d     = HOLD_W'(HOLD_CYC);
      state_d    = ST_LOAD;
    end

    ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      shd_q      <= '0;
      hold_q     <= '0;
      ready_q    <= 1'b0;
      x_q        <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      in_ready_q <= 1'b0;
      wv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      shd_q      <= shd_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      x_q        <= x_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      in_ready_q <= in_ready_d;
      wv_q       <= wv_d;
      err_q      <= err_d;
    end
  end

  assign s_ready       = ready_q;
  assign x_flat        = x_q;
  assign w1_flat       = w1_q;
  assign w2_flat       = w2_q;
  assign in_ready      = in_ready_q;
  assign weights_valid = wv_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_dnn_param_loader.sv
// Directed + randomized-valid bench for dnn_param_loader with a commit scoreboard.
module tb_dnn_param_loader;
  import dnn_param_loader_pkg::*;

  localparam int unsigned CW = W1_W;

  typedef struct packed {
    logic [X_W-1:0]  x;
    logic [W1_W-1:0] w1;
    logic [W2_W-1:0] w2;
    logic            wv;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DW-1:0]     s_data = '0;
  logic              s_wload = 1'b0;
  logic              s_last = 1'b0;
  logic [X_W-1:0]    x_flat;
  logic [W1_W-1:0]   w1_flat;
  logic [W2_W-1:0]   w2_flat;
  logic              in_ready;
  logic              weights_valid;
  logic              frame_err;

  always #5 clk = ~clk;

  dnn_param_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_wload       (s_wload),
    .s_last        (s_last),
    .x_flat        (x_flat),
    .w1_flat       (w1_flat),
    .w2_flat       (w2_flat),
    .in_ready      (in_ready),
    .weights_valid (weights_valid),
    .frame_err     (frame_err)
  );

  exp_t            sbq[$];
  exp_t            mon_e;
  logic [DW-1:0]   frm[FRAME_FULL];
  logic [X_W-1:0]  mx;
  logic [W1_W-1:0] mw1;
  logic [W2_W-1:0] mw2;
  logic            mwv;
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              last_ir = -100;
  int              ir_cnt = 0;
  int              err_cnt = 0;
  int              ir0;
  logic            prev_rst_n = 1'b0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = '0; mw1 = '0; mw2 = '0; mwv = 1'b0;
    sbq.delete();
  endtask

  task automatic push_exp(input bit full);
    exp_t e;
    for (int k = 0; k < int'(N_IN); k++) mx[DW*k +: DW] = frm[k];
    if (full) begin
      for (int k = 0; k < int'(N_IN*N_HID); k++) mw1[DW*k +: DW] = frm[IDX_W1 + k];
      for (int k = 0; k < int'(N_HID*N_OUT); k++) mw2[DW*k +: DW] = frm[IDX_W2 + k];
      mwv = 1'b1;
    end
    e.x = mx; e.w1 = mw1; e.w2 = mw2; e.wv = mwv;
    sbq.push_back(e);
  endtask

  task automatic load_rand();
    for (int i = 0; i < int'(FRAME_FULL); i++) frm[i] = DW'($urandom);
  endtask

  // Drives n words; returns just after the edge that accepted the last one.
  task automatic send(input int n, input int last_at, input bit full, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      int guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        s_data  = frm[i];
        s_wload = full;
        s_last  = (i == last_at);
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        acc     = s_valid && s_ready;
        @(posedge clk);
        guard++;
      end
      total++;
      assert (acc) else begin
        bad++;
        $error("FAIL accept_timeout observed=%0d expected=1 word=%0d", acc, i);
      end
    end
  endtask

  task automatic idle_negedge();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_s_ready", CW'(s_ready), CW'(0));
    chk("rst_x", CW'(x_flat), CW'(0));
    chk("rst_w1", w1_flat, CW'(0));
    chk("rst_w2", CW'(w2_flat), CW'(0));
    chk("rst_flags", CW'({in_ready, weights_valid, frame_err}), CW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_s_ready", CW'(s_ready), CW'(1));
  endtask

  // Commit monitor: every in_ready must match the oldest expected frame.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && prev_rst_n) begin
      total++;
      assert (s_ready || sbq.size() > 0) else begin
        bad++;
        $error("FAIL s_ready_low observed=%0d expected=1", s_ready);
      end
    end
    prev_rst_n = rst_n;
    if (!rst_n) begin
      last_ir = -100;
    end else if (in_ready) begin
      ir_cnt++;
      total++;
      assert (!frame_err) else begin
        bad++;
        $error("FAIL ir_err_overlap observed=%0d expected=0", frame_err);
      end
      total++;
      assert (cyc - last_ir >= int'(HOLD_CYC) + 1) else begin
        bad++;
        $error("FAIL ir_spacing observed=%0d expected>=%0d", cyc - last_ir, HOLD_CYC + 1);
      end
      last_ir = cyc;
      total++;
      assert (sbq.size() > 0) else begin
        bad++;
        $error("FAIL ir_unexpected observed=1 expected=0");
      end
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("sb_x", CW'(x_flat), CW'(mon_e.x));
        chk("sb_w1", w1_flat, mon_e.w1);
        chk("sb_w2", CW'(w2_flat), CW'(mon_e.w2));
        chk("sb_wv", CW'(weights_valid), CW'(mon_e.wv));
      end
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    model_reset();
    do_reset();

    // Counting frame 1..28 with w79 = -4
    for (int i = 0; i < int'(FRAME_FULL); i++) frm[i] = DW'(i + 1);
    frm[FRAME_FULL-1] = 5'h1C;
    push_exp(1'b1);
    send(28, 27, 1'b1, 1'b0);
    idle_negedge();
    chk("t1_in_ready", CW'(in_ready), CW'(1));
    chk("t1_x0", CW'(x_flat[4:0]), CW'(5'h01));
    chk("t1_w79", CW'(w2_flat[39:35]), CW'(5'h1C));
    chk("t1_wv", CW'(weights_valid), CW'(1));
    @(negedge clk);
    chk("t1_pulse_len", CW'(in_ready), CW'(0));

    // Full frame then back-to-back x-only frame
    load_rand();
    push_exp(1'b1);
    send(28, 27, 1'b1, 1'b0);
    frm[0] = 5'h10; frm[1] = 5'h0F; frm[2] = 5'h00; frm[3] = 5'h1F;
    push_exp(1'b0);
    send(4, 3, 1'b0, 1'b0);
    idle_negedge();
    chk("t2_in_ready", CW'(in_ready), CW'(1));
    chk("t2_x3", CW'(x_flat[19:15]), CW'(5'h1F));
    chk("t2_x0", CW'(x_flat[4:0]), CW'(5'h10));
    chk("t2_w1_kept", w1_flat, mw1);
    chk("t2_w2_kept", CW'(w2_flat), CW'(mw2));

    // Early s_last on word 20, then missing s_last, then a good frame
    repeat (3) @(negedge clk);
    load_rand();
    send(20, 19, 1'b1, 1'b0);
    idle_negedge();
    chk("t4_err_early", CW'(frame_err), CW'(1));
    chk("t4_no_ir", CW'(in_ready), CW'(0));
    chk("t4_x_kept", CW'(x_flat), CW'(mx));
    chk("t4_w1_kept", w1_flat, mw1);
    @(negedge clk);
    chk("t4_err_pulse", CW'(frame_err), CW'(0));
    load_rand();
    send(28, -1, 1'b1, 1'b0);
    idle_negedge();
    chk("t4_err_missing", CW'(frame_err), CW'(1));
    chk("t4_w2_kept", CW'(w2_flat), CW'(mw2));
    load_rand();
    push_exp(1'b1);
    send(28, 27, 1'b1, 1'b0);
    idle_negedge();
    chk("t4_recover_ir", CW'(in_ready), CW'(1));

    // x-only frame straight after reset
    do_reset();
    frm[0] = 5'h03; frm[1] = 5'h04; frm[2] = 5'h05; frm[3] = 5'h06;
    ir0 = ir_cnt;
    send(4, 3, 1'b0, 1'b0);
    idle_negedge();
    chk("t3_err", CW'(frame_err), CW'(1));
    chk("t3_no_ir", CW'(in_ready), CW'(0));
    chk("t3_x_zero", CW'(x_flat), CW'(0));
    chk("t3_wv", CW'(weights_valid), CW'(0));
    repeat (4) @(negedge clk);
    chk("t3_ir_count", CW'(ir_cnt - ir0), CW'(0));

    // Reset at word 15 of a frame, then a fresh frame
    load_rand();
    send(15, -1, 1'b1, 1'b0);
    do_reset();
    load_rand();
    push_exp(1'b1);
    ir0 = ir_cnt;
    send(28, 27, 1'b1, 1'b0);
    idle_negedge();
    repeat (8) @(negedge clk);
    chk("t5_ir_count", CW'(ir_cnt - ir0), CW'(1));
    chk("t5_x", CW'(x_flat), CW'(mx));
    chk("t5_w1", w1_flat, mw1);

    // Random s_valid over mixed full / x-only frames
    for (int k = 0; k < 6; k++) begin
      bit full = (k != 1) && (k != 4);
      int n = full ? int'(FRAME_FULL) : int'(FRAME_X);
      load_rand();
      push_exp(full);
      send(n, n - 1, full, 1'b1);
    end
    idle_negedge();
    for (int t = 0; t < 100 && sbq.size() > 0; t++) @(negedge clk);
    chk("t6_drained", CW'(sbq.size()), CW'(0));
    chk("t6_x", CW'(x_flat), CW'(mx));
    chk("t6_w2", CW'(w2_flat), CW'(mw2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
